// File: rtl/nanomips_pkg.sv
// rtl/nanomips_pkg.sv - shared nanoMIPS datapath widths, ALU control codes and operand types
package nanomips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int IMM_W    = 16;
   localparam int NUM_REGS = 1 << ADDR_W;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [IMM_W-1:0]  imm_t;

   typedef struct packed {
      word_t      a;
      word_t      b;
      logic [3:0] aluctr;
      reg_addr_t  rd;
      logic       regwrite;
   } slot_t;

   function automatic word_t extend_imm(input imm_t imm, input logic signext);
      return signext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                     : {{(DATA_W-IMM_W){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - issue-side and ALU-side handshake bundle of the operand stage
interface alu_operand_stage_if;
   import nanomips_pkg::*;

   logic       in_valid;
   logic       in_ready;
   reg_addr_t  in_rs;
   reg_addr_t  in_rt;
   imm_t       in_imm;
   logic       in_alusrc;
   logic       in_signext;
   logic [3:0] in_aluctr;
   reg_addr_t  in_rd;
   logic       in_regwrite;

   logic       out_valid;
   logic       out_ready;
   word_t      out_a;
   word_t      out_b;
   logic [3:0] out_aluctr;
   reg_addr_t  out_rd;
   logic       out_regwrite;

   modport master (
      output in_valid, in_rs, in_rt, in_imm, in_alusrc, in_signext,
             in_aluctr, in_rd, in_regwrite, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_aluctr, out_rd, out_regwrite
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_imm, in_alusrc, in_signext,
             in_aluctr, in_rd, in_regwrite, out_ready,
      output in_ready, out_valid, out_a, out_b, out_aluctr, out_rd, out_regwrite
   );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 32x32 GPR file: two async read ports, debug read, one sync write, $0 hardwired
module alu_regfile
   import nanomips_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  reg_addr_t ra_addr,
   output word_t     ra_data,
   input  reg_addr_t rb_addr,
   output word_t     rb_data,
   input  reg_addr_t dbg_addr,
   output word_t     dbg_data,
   input  logic      we,
   input  reg_addr_t wa,
   input  word_t     wd
);

   word_t mem_q [NUM_REGS];
   word_t mem_d [NUM_REGS];

   always_comb begin
      mem_d = mem_q;
      if (we && wa != '0) begin
         mem_d[wa] = wd;
      end
      mem_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Reads return the pre-edge contents; a same-cycle write is not visible here.
   assign ra_data  = (ra_addr  == '0) ? '0 : mem_q[ra_addr];
   assign rb_data  = (rb_addr  == '0) ? '0 : mem_q[rb_addr];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand issue stage: GPR read, B select, busy scoreboard, output slot
// OPSTAGE_WB_BYPASS_EN forwards same-cycle writeback data into the operands and releases the stall.
module alu_operand_stage
   import nanomips_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   alu_operand_stage_if.slave  io,
   input  logic                wb_en,
   input  reg_addr_t           wb_addr,
   input  word_t               wb_data,
   input  reg_addr_t           dbg_addr,
   output word_t               dbg_data
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   slot_t               slot_q, slot_d;
   logic                valid_q, valid_d;

   word_t rf_a, rf_b;
   word_t opnd_a, opnd_b;
   logic  busy_rs, busy_rt, hazard, in_ready_c, fire;

   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra_addr  (io.in_rs),
      .ra_data  (rf_a),
      .rb_addr  (io.in_rt),
      .rb_data  (rf_b),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (wb_en),
      .wa       (wb_addr),
      .wd       (wb_data)
   );

   always_comb begin
      opnd_a  = rf_a;
      opnd_b  = rf_b;
      busy_rs = busy_q[io.in_rs];
      busy_rt = busy_q[io.in_rt];
`ifdef OPSTAGE_WB_BYPASS_EN
      // A source that is also this instruction's destination stays stalled so it re-reads cleanly.
      if (wb_en && wb_addr == io.in_rs && io.in_rs != '0) begin
         opnd_a = wb_data;
         if (!(io.in_regwrite && io.in_rd == io.in_rs)) begin
            busy_rs = 1'b0;
         end
      end
      if (wb_en && wb_addr == io.in_rt && io.in_rt != '0) begin
         opnd_b = wb_data;
         if (!(io.in_regwrite && io.in_rd == io.in_rt)) begin
            busy_rt = 1'b0;
         end
      end
`endif
      hazard     = busy_rs | (!io.in_alusrc & busy_rt);
      in_ready_c = (!valid_q | io.out_ready) & !hazard;
      fire       = io.in_valid & in_ready_c;
   end

   // Set after clear: a new producer issued alongside a writeback to the same reg stays outstanding.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (fire && io.in_regwrite && io.in_rd != '0) begin
         busy_d[io.in_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      if (fire) begin
         valid_d         = 1'b1;
         slot_d.a        = opnd_a;
         slot_d.b        = io.in_alusrc ? extend_imm(io.in_imm, io.in_signext) : opnd_b;
         slot_d.aluctr   = io.in_aluctr;
         slot_d.rd       = io.in_rd;
         slot_d.regwrite = io.in_regwrite;
      end else if (io.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         slot_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         slot_q  <= slot_d;
         valid_q <= valid_d;
      end
   end

   assign io.in_ready     = in_ready_c;
   assign io.out_valid    = valid_q;
   assign io.out_a        = slot_q.a;
   assign io.out_b        = slot_q.b;
   assign io.out_aluctr   = slot_q.aluctr;
   assign io.out_rd       = slot_q.rd;
   assign io.out_regwrite = slot_q.regwrite;

endmodule
